// File: rtl/result_packer.sv
// Packs per-channel byte writes into 128-bit words; one hold slot per channel, round-robin into one output register.
// Latency: completing write at edge N lands in hold at N, pk_valid after N+1. Stall: pk_ready=0 freezes outputs; a flush into a full hold is dropped and flagged in overflow.
// Build option: RESULT_PACKER_STATS_EN enables the pk_words accepted-word counter.
module result_packer #(
    parameter int WORD_ADDR_W = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   output_we_0,
    input  logic                   output_we_1,
    input  logic                   output_we_2,
    input  logic [15:0]            output_addr_0,
    input  logic [15:0]            output_addr_1,
    input  logic [15:0]            output_addr_2,
    input  logic [7:0]             y_0,
    input  logic [7:0]             y_1,
    input  logic [7:0]             y_2,
    input  logic                   flush_req,
    output logic                   pk_valid,
    input  logic                   pk_ready,
    output logic [127:0]           pk_data,
    output logic [15:0]            pk_mask,
    output logic [WORD_ADDR_W-1:0] pk_addr,
    output logic [1:0]             pk_chan,
    output logic [2:0]             overflow,
    output logic [15:0]            pk_words
);
    localparam int NCH = 3;

    typedef struct packed {
        logic [127:0]           data;
        logic [15:0]            mask;
        logic [WORD_ADDR_W-1:0] addr;
    } word_t;

    logic [NCH-1:0] we;
    logic [15:0]    wr_addr [NCH];
    logic [7:0]     wr_byte [NCH];

    assign we         = {output_we_2, output_we_1, output_we_0};
    assign wr_addr[0] = output_addr_0;
    assign wr_addr[1] = output_addr_1;
    assign wr_addr[2] = output_addr_2;
    assign wr_byte[0] = y_0;
    assign wr_byte[1] = y_1;
    assign wr_byte[2] = y_2;

    word_t          acc_q  [NCH];
    word_t          acc_d  [NCH];
    word_t          hold_q [NCH];
    word_t          hold_d [NCH];
    logic [NCH-1:0] busy_q, busy_d;
    logic [NCH-1:0] hold_vld_q, hold_vld_d;
    logic [NCH-1:0] ovf_q, ovf_d;
    word_t          out_q, out_d;
    logic           out_vld_q, out_vld_d;
    logic [1:0]     out_chan_q, out_chan_d;
    logic [1:0]     last_q, last_d;

    logic           out_free;
    logic [NCH-1:0] grant;
    logic [1:0]     gnt_idx;
    logic [2:0]     cand;

    assign out_free = !out_vld_q || pk_ready;

    // Round-robin: search starts at the channel after the last one granted.
    always_comb begin
        grant   = '0;
        gnt_idx = last_q;
        cand    = '0;
        if (out_free) begin
            for (int k = 1; k <= NCH; k++) begin
                cand = {1'b0, last_q} + 3'(k);
                if (cand >= 3'(NCH)) cand = cand - 3'(NCH);
                if (grant == '0 && hold_vld_q[cand[1:0]]) begin
                    grant[cand[1:0]] = 1'b1;
                    gnt_idx          = cand[1:0];
                end
            end
        end
    end

    always_comb begin
        word_t                  merged;
        logic                   flush_old;
        logic                   flush_new;
        logic                   hold_free;
        logic [3:0]             lane;
        logic [WORD_ADDR_W-1:0] waddr;
        for (int c = 0; c < NCH; c++) begin
            acc_d[c]      = acc_q[c];
            busy_d[c]     = busy_q[c];
            hold_d[c]     = hold_q[c];
            hold_vld_d[c] = hold_vld_q[c] & ~grant[c];
            ovf_d[c]      = ovf_q[c];
            lane          = wr_addr[c][3:0];
            waddr         = WORD_ADDR_W'(wr_addr[c][15:4]);
            merged        = acc_q[c];
            flush_old     = 1'b0;
            flush_new     = 1'b0;
            if (we[c]) begin
                flush_old = busy_q[c] && (acc_q[c].addr != waddr);
                if (!busy_q[c] || flush_old) begin
                    merged      = '0;
                    merged.addr = waddr;
                end
                merged.data[{lane, 3'b000} +: 8] = wr_byte[c];
                merged.mask[lane]                = 1'b1;
                flush_new = (lane == 4'hF) || flush_req;
                acc_d[c]  = merged;
                busy_d[c] = !flush_new;
            end else if (flush_req && busy_q[c]) begin
                flush_new = 1'b1;
                busy_d[c] = 1'b0;
            end
            // The displaced old word claims hold first; a second flush in the same cycle finds it full.
            hold_free = !hold_vld_q[c] || grant[c];
            if (flush_old) begin
                if (hold_free) begin
                    hold_d[c]     = acc_q[c];
                    hold_vld_d[c] = 1'b1;
                    hold_free     = 1'b0;
                end else begin
                    ovf_d[c] = 1'b1;
                end
            end
            if (flush_new) begin
                if (hold_free) begin
                    hold_d[c]     = merged;
                    hold_vld_d[c] = 1'b1;
                end else begin
                    ovf_d[c] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q && !pk_ready;
        out_chan_d = out_chan_q;
        last_d     = last_q;
        if (grant != '0) begin
            out_d      = hold_q[gnt_idx];
            out_vld_d  = 1'b1;
            out_chan_d = gnt_idx;
            last_d     = gnt_idx;
        end
    end

    // last_q reset to 2 so that channel 0 is first in line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NCH; c++) begin
                acc_q[c]  <= '0;
                hold_q[c] <= '0;
            end
            busy_q     <= '0;
            hold_vld_q <= '0;
            ovf_q      <= '0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            out_chan_q <= '0;
            last_q     <= 2'd2;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                acc_q[c]  <= acc_d[c];
                hold_q[c] <= hold_d[c];
            end
            busy_q     <= busy_d;
            hold_vld_q <= hold_vld_d;
            ovf_q      <= ovf_d;
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            out_chan_q <= out_chan_d;
            last_q     <= last_d;
        end
    end

    assign pk_valid = out_vld_q;
    assign pk_data  = out_q.data;
    assign pk_mask  = out_q.mask;
    assign pk_addr  = out_q.addr;
    assign pk_chan  = out_chan_q;
    assign overflow = ovf_q;

`ifdef RESULT_PACKER_STATS_EN
    logic [15:0] words_q, words_d;

    always_comb begin
        words_d = words_q;
        if (out_vld_q && pk_ready) words_d = words_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) words_q <= '0;
        else      words_q <= words_d;
    end

    assign pk_words = words_q;
`else
    assign pk_words = '0;
`endif

endmodule
